// File: rtl/wb2axi.sv
// rtl/wb2axi.sv - Wishbone classic 32-bit slave to AXI4-Lite 64-bit master bridge
module wb2axi #(
    parameter int AW = 12
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-3:0] i_wb_adr,
    input  logic [31:0]   i_wb_dat,
    input  logic [3:0]    i_wb_sel,
    input  logic          i_wb_we,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    output logic [31:0]   o_wb_rdt,
    output logic          o_wb_ack,
    output logic          o_wb_err,
    output logic [AW-1:0] o_awaddr,
    output logic          o_awvalid,
    input  logic          i_awready,
    output logic [63:0]   o_wdata,
    output logic [7:0]    o_wstrb,
    output logic          o_wvalid,
    input  logic          i_wready,
    input  logic [1:0]    i_bresp,
    input  logic          i_bvalid,
    output logic          o_bready,
    output logic [AW-1:0] o_araddr,
    output logic          o_arvalid,
    input  logic          i_arready,
    input  logic [63:0]   i_rdata,
    input  logic [1:0]    i_rresp,
    input  logic          i_rvalid,
    output logic          o_rready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WADDR = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_RADDR = 3'd3;
    localparam logic [2:0] S_RRESP = 3'd4;
    localparam logic [2:0] S_ACK   = 3'd5;

    logic [2:0] state;
    logic       hi_half;
    logic       aw_done_now;
    logic       w_done_now;

    // Only bit 1 of a response distinguishes OKAY/EXOKAY from SLVERR/DECERR
    logic unused_resp;
    assign unused_resp = ^{i_bresp[0], i_rresp[0]};

    assign aw_done_now = !o_awvalid || i_awready;
    assign w_done_now  = !o_wvalid || i_wready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            hi_half   <= 1'b0;
            o_wb_rdt  <= 32'h0;
            o_wb_ack  <= 1'b0;
            o_wb_err  <= 1'b0;
            o_awaddr  <= '0;
            o_awvalid <= 1'b0;
            o_wdata   <= 64'h0;
            o_wstrb   <= 8'h0;
            o_wvalid  <= 1'b0;
            o_bready  <= 1'b0;
            o_araddr  <= '0;
            o_arvalid <= 1'b0;
            o_rready  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_wb_cyc && i_wb_stb) begin
                        o_awaddr <= {i_wb_adr[AW-3:1], 3'b000};
                        o_araddr <= {i_wb_adr[AW-3:1], 3'b000};
                        hi_half  <= i_wb_adr[0];
                        if (i_wb_we) begin
                            o_wdata   <= {i_wb_dat, i_wb_dat};
                            o_wstrb   <= i_wb_adr[0] ? {i_wb_sel, 4'h0} : {4'h0, i_wb_sel};
                            o_awvalid <= 1'b1;
                            o_wvalid  <= 1'b1;
                            state     <= S_WADDR;
                        end else begin
                            o_arvalid <= 1'b1;
                            state     <= S_RADDR;
                        end
                    end
                end
                S_WADDR: begin
                    if (o_awvalid && i_awready)
                        o_awvalid <= 1'b0;
                    if (o_wvalid && i_wready)
                        o_wvalid <= 1'b0;
                    if (aw_done_now && w_done_now) begin
                        o_bready <= 1'b1;
                        state    <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (i_bvalid) begin
                        o_bready <= 1'b0;
                        o_wb_err <= i_bresp[1];
                        o_wb_ack <= !i_bresp[1];
                        state    <= S_ACK;
                    end
                end
                S_RADDR: begin
                    if (i_arready) begin
                        o_arvalid <= 1'b0;
                        o_rready  <= 1'b1;
                        state     <= S_RRESP;
                    end
                end
                S_RRESP: begin
                    if (i_rvalid) begin
                        o_rready <= 1'b0;
                        o_wb_rdt <= hi_half ? i_rdata[63:32] : i_rdata[31:0];
                        o_wb_err <= i_rresp[1];
                        o_wb_ack <= !i_rresp[1];
                        state    <= S_ACK;
                    end
                end
                S_ACK: begin
                    // stb may still be high here; the request is not re-sampled
                    o_wb_ack <= 1'b0;
                    o_wb_err <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
